// File: rtl/odu_sched_pkg.sv
// Shared constants, register map and FSM state type for the ODU channel scheduler.
package odu_sched_pkg;

  localparam int CHID_W = 7;
  localparam int MAX_CH = 16;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_MASK    = 4'd1;
  localparam logic [3:0] ADDR_ROW_LEN = 4'd2;
  localparam logic [3:0] ADDR_ROWS    = 4'd3;
  localparam logic [3:0] ADDR_WEIGHT0 = 4'd4;
  localparam logic [3:0] ADDR_WEIGHT1 = 4'd5;
  localparam logic [3:0] ADDR_WEIGHT2 = 4'd6;
  localparam logic [3:0] ADDR_WEIGHT3 = 4'd7;
  localparam logic [3:0] ADDR_STATUS  = 4'd8;

  localparam logic [7:0] ROW_LEN_RST = 8'd80;
  localparam logic [3:0] ROWS_RST    = 4'd4;
  localparam logic [3:0] WEIGHT_RST  = 4'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    OFFER = 2'd2
  } sched_state_e;

  // Zero-valued lengths and weights are promoted to one.
  function automatic logic [3:0] nz4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  function automatic logic [7:0] nz8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/odu_sched_cfg_regs.sv
// cfg-bus front end: write-strobe edge detect, configuration register file
// and registered read-back mux.
module odu_sched_cfg_regs
  import odu_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_n_cs,
  input  logic              cfg_n_we,
  input  logic              cfg_n_oe,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_din,
  input  logic              status_valid,
  input  logic [CHID_W-1:0] status_chid,
  output logic              en,
  output logic              clr,
  output logic [15:0]       mask,
  output logic [7:0]        row_len,
  output logic [3:0]        rows,
  output logic [63:0]       weights,
  output logic [15:0]       cfg_dout
);

  logic        we_n_dly_q, we_n_dly_d;
  logic        en_q, en_d;
  logic        clr_q, clr_d;
  logic [15:0] mask_q, mask_d;
  logic [7:0]  row_len_q, row_len_d;
  logic [3:0]  rows_q, rows_d;
  logic [63:0] weights_q, weights_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata;
  logic        wr_stb;
  logic        rd_stb;

  // One commit per strobe: only the first low cycle of cfg_n_we writes.
  assign wr_stb = ~cfg_n_cs & ~cfg_n_we & we_n_dly_q;
  assign rd_stb = ~cfg_n_cs & ~cfg_n_oe;

  always_comb begin
    we_n_dly_d = cfg_n_we;
    en_d       = en_q;
    clr_d      = 1'b0;
    mask_d     = mask_q;
    row_len_d  = row_len_q;
    rows_d     = rows_q;
    weights_d  = weights_q;
    if (wr_stb) begin
      case (cfg_addr)
        ADDR_CTRL: begin
          en_d  = cfg_din[0];
          clr_d = cfg_din[1] & ~en_q;
        end
        ADDR_MASK:    mask_d    = cfg_din;
        ADDR_ROW_LEN: row_len_d = cfg_din[7:0];
        ADDR_ROWS:    rows_d    = cfg_din[3:0];
        ADDR_WEIGHT0, ADDR_WEIGHT1, ADDR_WEIGHT2, ADDR_WEIGHT3:
          weights_d[{cfg_addr[1:0], 4'b0000} +: 16] = cfg_din;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:    rdata = {15'd0, en_q};
      ADDR_MASK:    rdata = mask_q;
      ADDR_ROW_LEN: rdata = {8'd0, row_len_q};
      ADDR_ROWS:    rdata = {12'd0, rows_q};
      ADDR_WEIGHT0, ADDR_WEIGHT1, ADDR_WEIGHT2, ADDR_WEIGHT3:
        rdata = weights_q[{cfg_addr[1:0], 4'b0000} +: 16];
      ADDR_STATUS:  rdata = {status_valid, 8'd0, status_chid};
      default:      rdata = '0;
    endcase
    dout_d = rd_stb ? rdata : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_n_dly_q <= 1'b1;
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      mask_q     <= '0;
      row_len_q  <= ROW_LEN_RST;
      rows_q     <= ROWS_RST;
      weights_q  <= {16{WEIGHT_RST}};
      dout_q     <= '0;
    end else begin
      we_n_dly_q <= we_n_dly_d;
      en_q       <= en_d;
      clr_q      <= clr_d;
      mask_q     <= mask_d;
      row_len_q  <= row_len_d;
      rows_q     <= rows_d;
      weights_q  <= weights_d;
      dout_q     <= dout_d;
    end
  end

  assign en       = en_q;
  assign clr      = clr_q;
  assign mask     = mask_q;
  assign row_len  = row_len_q;
  assign rows     = rows_q;
  assign weights  = weights_q;
  assign cfg_dout = dout_q;

endmodule

// File: rtl/odu_chan_sched.sv
// Weighted round-robin word-slot scheduler for the ODU generator channels,
// with per-channel row/frame position counters driving the framing flags.
module odu_chan_sched
  import odu_sched_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter logic [CHID_W-1:0] CHID_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_n_cs,
  input  logic              cfg_n_we,
  input  logic              cfg_n_oe,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_din,
  output logic [15:0]       cfg_dout,
  output logic              sched_valid,
  input  logic              sched_ready,
  output logic [CHID_W-1:0] sched_chid,
  output logic              sched_fs_start,
  output logic              sched_rs_start
);

  localparam logic [15:0] CH_MASK = 16'((32'h1 << NUM_CH) - 32'h1);
  localparam logic [3:0]  LAST_CH = 4'(NUM_CH - 1);

  logic              en;
  logic              clr;
  logic [15:0]       mask;
  logic [7:0]        row_len;
  logic [3:0]        rows;
  logic [63:0]       weights;

  sched_state_e      state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        cur_q, cur_d;
  logic [3:0]        burst_q, burst_d;
  logic [CHID_W-1:0] last_chid_q, last_chid_d;
  logic [7:0]        word_cnt_q [MAX_CH];
  logic [7:0]        word_cnt_d [MAX_CH];
  logic [3:0]        row_cnt_q  [MAX_CH];
  logic [3:0]        row_cnt_d  [MAX_CH];

  logic [15:0]       live_mask;
  logic              runnable;
  logic              pick_found;
  logic [3:0]        pick_ch;
  logic [CHID_W-1:0] cur_chid;
  logic              cur_rs;
  logic              cur_fs;
  logic [7:0]        row_last;
  logic [3:0]        frame_last;

  odu_sched_cfg_regs u_cfg (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_n_cs     (cfg_n_cs),
    .cfg_n_we     (cfg_n_we),
    .cfg_n_oe     (cfg_n_oe),
    .cfg_addr     (cfg_addr),
    .cfg_din      (cfg_din),
    .status_valid (sched_valid),
    .status_chid  (last_chid_q),
    .en           (en),
    .clr          (clr),
    .mask         (mask),
    .row_len      (row_len),
    .rows         (rows),
    .weights      (weights),
    .cfg_dout     (cfg_dout)
  );

  assign live_mask  = mask & CH_MASK;
  assign runnable   = en & (|live_mask);
  assign cur_chid   = CHID_BASE + {3'd0, cur_q};
  assign cur_rs     = (word_cnt_q[cur_q] == 8'd0);
  assign cur_fs     = cur_rs & (row_cnt_q[cur_q] == 4'd0);
  assign row_last   = nz8(row_len) - 8'd1;
  assign frame_last = nz4(rows) - 4'd1;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    logic [4:0] idx;
    pick_found = 1'b0;
    pick_ch    = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_q} + 5'(i);
      if (idx >= 5'(NUM_CH)) idx = idx - 5'(NUM_CH);
      if (!pick_found && live_mask[idx[3:0]]) begin
        pick_found = 1'b1;
        pick_ch    = idx[3:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    burst_d     = burst_q;
    last_chid_d = last_chid_q;
    word_cnt_d  = word_cnt_q;
    row_cnt_d   = row_cnt_q;
    case (state_q)
      IDLE: begin
        if (runnable) state_d = SEL;
      end
      SEL: begin
        if (runnable && pick_found) begin
          cur_d   = pick_ch;
          burst_d = nz4(weights[{pick_ch, 2'b00} +: 4]);
          state_d = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        if (sched_ready) begin
          burst_d     = burst_q - 4'd1;
          last_chid_d = cur_chid;
          // >= so a shrunken ROW_LEN/ROWS wraps on the next acceptance.
          if (word_cnt_q[cur_q] >= row_last) begin
            word_cnt_d[cur_q] = 8'd0;
            row_cnt_d[cur_q]  = (row_cnt_q[cur_q] >= frame_last) ? 4'd0 : row_cnt_q[cur_q] + 4'd1;
          end else begin
            word_cnt_d[cur_q] = word_cnt_q[cur_q] + 8'd1;
          end
          if (burst_q == 4'd1 || !live_mask[cur_q] || !en) begin
            ptr_d   = (cur_q == LAST_CH) ? 4'd0 : cur_q + 4'd1;
            state_d = runnable ? SEL : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      ptr_d = '0;
      for (int i = 0; i < MAX_CH; i++) begin
        word_cnt_d[i] = '0;
        row_cnt_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_q       <= '0;
      burst_q     <= '0;
      last_chid_q <= '0;
      for (int i = 0; i < MAX_CH; i++) begin
        word_cnt_q[i] <= '0;
        row_cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      burst_q     <= burst_d;
      last_chid_q <= last_chid_d;
      word_cnt_q  <= word_cnt_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  assign sched_valid    = (state_q == OFFER);
  assign sched_chid     = sched_valid ? cur_chid : '0;
  assign sched_rs_start = sched_valid & cur_rs;
  assign sched_fs_start = sched_valid & cur_fs;

endmodule

// File: tb/tb_odu_chan_sched.sv
// Scoreboard bench for odu_chan_sched: expected grants are queued as stimulus
// is set up and checked against each accepted handshake.
module tb_odu_chan_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_n_cs = 1'b1;
  logic        cfg_n_we = 1'b1;
  logic        cfg_n_oe = 1'b1;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_din = '0;
  logic [15:0] cfg_dout;
  logic        sched_valid;
  logic        sched_ready = 1'b0;
  logic [6:0]  sched_chid;
  logic        sched_fs_start;
  logic        sched_rs_start;

  odu_chan_sched #(.NUM_CH(8), .CHID_BASE(7'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_n_cs       (cfg_n_cs),
    .cfg_n_we       (cfg_n_we),
    .cfg_n_oe       (cfg_n_oe),
    .cfg_addr       (cfg_addr),
    .cfg_din        (cfg_din),
    .cfg_dout       (cfg_dout),
    .sched_valid    (sched_valid),
    .sched_ready    (sched_ready),
    .sched_chid     (sched_chid),
    .sched_fs_start (sched_fs_start),
    .sched_rs_start (sched_rs_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int chid;
    int fs;
    int rs;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t mon_e;
  int   m_word[16];
  int   m_row[16];
  int   m_rowlen;
  int   m_rows;
  logic [15:0] rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Independent model of the per-channel framing position.
  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_word[i] = 0;
      m_row[i]  = 0;
    end
  endtask

  task automatic push_grant(input int ch, input int gap);
    exp_t e;
    int rl, rw;
    rl = (m_rowlen == 0) ? 1 : m_rowlen;
    rw = (m_rows == 0) ? 1 : m_rows;
    e.chid = ch;
    e.rs   = (m_word[ch] == 0) ? 1 : 0;
    e.fs   = (e.rs == 1 && m_row[ch] == 0) ? 1 : 0;
    e.gap  = gap;
    sb_q.push_back(e);
    if (m_word[ch] >= rl - 1) begin
      m_word[ch] = 0;
      if (m_row[ch] >= rw - 1) m_row[ch] = 0;
      else m_row[ch] = m_row[ch] + 1;
    end else begin
      m_word[ch] = m_word[ch] + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sched_valid && sched_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_grant", sched_chid, -1);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("grant_chid", sched_chid, mon_e.chid);
        check_val("grant_fs", sched_fs_start, mon_e.fs);
        check_val("grant_rs", sched_rs_start, mon_e.rs);
        if (mon_e.gap != 0) check_val("grant_gap", cyc - last_acc, mon_e.gap);
      end
      last_acc = cyc;
    end
  end

  // Data is deliberately corrupted after the first low cycle: only the
  // first cycle of a strobe may commit.
  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, input int hold = 1);
    @(posedge clk); #1;
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = a; cfg_din = d;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      cfg_din = ~d;
    end
    cfg_n_we = 1'b1; cfg_n_cs = 1'b1;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    cfg_n_cs = 1'b0; cfg_n_oe = 1'b0; cfg_addr = a;
    @(posedge clk); #1;
    d = cfg_dout;
    cfg_n_cs = 1'b1; cfg_n_oe = 1'b1;
  endtask

  task automatic do_reset();
    check_val("sb_empty_before_reset", sb_q.size(), 0);
    sb_q.delete();
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_valid", sched_valid, 0);
    check_val("rst_chid", sched_chid, 0);
    check_val("rst_flags", {sched_fs_start, sched_rs_start}, 0);
    check_val("rst_dout", cfg_dout, 0);
    sched_ready = 1'b0;
    model_clear();
    m_rowlen = 80;
    m_rows   = 4;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!sched_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("wait_valid", sched_valid, 1);
  endtask

  task automatic accept_one();
    wait_valid();
    sched_ready = 1'b1;
    @(posedge clk); #1;
    sched_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1 sched_ready = 1'b0;
    check_val("drain", sb_q.size(), 0);
  endtask

  task automatic watch_idle(input string tag, input int ncyc);
    int hits = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (sched_valid) hits++;
    end
    check_val(tag, hits, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    // Reset defaults and readback, single write per long strobe
    do_reset();
    cfg_read(4'd2, rd); check_val("rst_row_len", rd, 80);
    cfg_read(4'd3, rd); check_val("rst_rows", rd, 4);
    cfg_read(4'd4, rd); check_val("rst_weight", rd, 16'h1111);
    cfg_read(4'd1, rd); check_val("rst_mask", rd, 0);
    cfg_read(4'd0, rd); check_val("rst_ctrl", rd, 0);
    cfg_write(4'd2, 16'h0005, 3);
    cfg_read(4'd2, rd); check_val("row_len_one_write", rd, 5);
    @(posedge clk); #1;
    check_val("dout_hold", cfg_dout, 5);
    cfg_write(4'd9, 16'h1234);
    cfg_read(4'd9, rd); check_val("unmapped_read", rd, 0);

    // Single channel framing sequence and enable latency
    do_reset();
    m_rowlen = 2; m_rows = 2;
    cfg_write(4'd1, 16'h0001);
    cfg_write(4'd2, 16'd2);
    cfg_write(4'd3, 16'd2);
    for (int k = 0; k < 5; k++) push_grant(0, (k == 0) ? 0 : 2);
    sched_ready = 1'b1;
    cfg_write(4'd0, 16'h0001);
    check_val("en_lat_t0", sched_valid, 0);
    @(posedge clk); #1;
    check_val("en_lat_t1", sched_valid, 0);
    @(posedge clk); #1;
    check_val("en_lat_t2", sched_valid, 1);
    drain();

    // Weighted round robin 3/1/2
    do_reset();
    cfg_write(4'd4, 16'h1213);
    cfg_write(4'd1, 16'h0007);
    for (int r = 0; r < 2; r++) begin
      push_grant(0, (r == 0) ? 0 : 2);
      push_grant(0, 1);
      push_grant(0, 1);
      push_grant(1, 2);
      push_grant(2, 2);
      push_grant(2, 1);
    end
    sched_ready = 1'b1;
    cfg_write(4'd0, 16'h0001);
    drain();
    cfg_read(4'd8, rd); check_val("status_offer", rd, 16'h8002);

    // Held offer stays stable; MASK clear does not retract it
    do_reset();
    cfg_write(4'd1, 16'h0001);
    cfg_write(4'd0, 16'h0001);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_val("hold_valid", sched_valid, 1);
      check_val("hold_chid", sched_chid, 0);
      check_val("hold_fs", sched_fs_start, 1);
      check_val("hold_rs", sched_rs_start, 1);
    end
    cfg_read(4'd8, rd); check_val("status_hold", rd, 16'h8000);
    cfg_write(4'd1, 16'h0000);
    check_val("mask_clr_keeps_offer", sched_valid, 1);
    push_grant(0, 0);
    sched_ready = 1'b1;
    drain();
    check_val("idle_after_mask_clr", sched_valid, 0);
    watch_idle("idle_after_mask_clr_watch", 5);

    // CLR ignored while enabled, honoured while disabled
    do_reset();
    m_rowlen = 3; m_rows = 2;
    cfg_write(4'd2, 16'd3);
    cfg_write(4'd3, 16'd2);
    cfg_write(4'd1, 16'h0001);
    cfg_write(4'd0, 16'h0001);
    push_grant(0, 0); accept_one();
    push_grant(0, 0); accept_one();
    cfg_write(4'd0, 16'h0003);
    push_grant(0, 0); accept_one();
    cfg_write(4'd0, 16'h0000);
    push_grant(0, 0); accept_one();
    watch_idle("idle_after_en_clr", 4);
    cfg_write(4'd0, 16'h0002);
    model_clear();
    cfg_read(4'd0, rd); check_val("ctrl_clr_selfclear", rd, 0);
    cfg_write(4'd0, 16'h0001);
    push_grant(0, 0); accept_one();
    check_val("sb_after_clr", sb_q.size(), 0);

    // Zero weight / row length / rows, and MASK bits beyond NUM_CH
    do_reset();
    m_rowlen = 0; m_rows = 0;
    cfg_write(4'd4, 16'h1101);
    cfg_write(4'd2, 16'd0);
    cfg_write(4'd3, 16'd0);
    cfg_write(4'd1, 16'hFF02);
    for (int k = 0; k < 4; k++) push_grant(1, (k == 0) ? 0 : 2);
    sched_ready = 1'b1;
    cfg_write(4'd0, 16'h0001);
    drain();
    cfg_write(4'd1, 16'hFF00);
    push_grant(1, 0);
    sched_ready = 1'b1;
    drain();
    sched_ready = 1'b1;
    watch_idle("high_mask_no_grant", 20);
    sched_ready = 1'b0;
    check_val("sb_final", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
